back_icon_iqueue_mc: RTL and testbench

- Multi-channel successor to the single-channel interconnect instruction queue.
- Holds NUM_CHANNELS independent first-word-fall-through instruction FIFOs, one per dispatch source, and presents one instruction at a time to the interconnect execution stage.
- A locked round-robin arbiter selects the channel. The block adds occupancy counts, almost-full, sticky overflow and synchronous flush.
- Storage is internal registers, not a sub-instantiated FIFO.

---
 rtl/back_icon_iqueue_mc.sv | 132 +++++++++++++
 tb/tb_back_icon_iqueue_mc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/back_icon_iqueue_mc.sv
// Per-channel FWFT instruction queues feeding one consumer through a locked round-robin arbiter.
// Write-to-head latency 1 cycle; a presented instruction is held (data and channel) until ready pops it.
module back_icon_iqueue_mc #(
  parameter int NUM_CHANNELS       = 2,
  parameter int LOG2_QUEUE_LENGTH  = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOST_FULL_THRESH = 2**LOG2_QUEUE_LENGTH-2,
  parameter int CH_W               = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]            dispatched_instr_i,
  input  logic [NUM_CHANNELS-1:0]                       dispatched_instr_valid_i,
  output logic [NUM_CHANNELS-1:0]                       is_full_o,
  output logic [NUM_CHANNELS-1:0]                       almost_full_o,
  output logic [NUM_CHANNELS*(LOG2_QUEUE_LENGTH+1)-1:0] count_o,
  output logic [NUM_CHANNELS-1:0]                       overflow_o,
  output logic [DATA_WIDTH-1:0]                         curr_instr_to_exec_o,
  output logic [CH_W-1:0]                               curr_instr_channel_o,
  output logic                                          curr_instr_to_exec_valid_o,
  input  logic                                          ready_for_next_instr_i
);

  localparam int DEPTH = 2**LOG2_QUEUE_LENGTH;
  localparam int CNT_W = LOG2_QUEUE_LENGTH + 1;

  typedef enum logic {ARB_FREE, ARB_HELD} arb_state_t;

  logic [DATA_WIDTH-1:0]        mem    [NUM_CHANNELS][DEPTH];
  logic [LOG2_QUEUE_LENGTH-1:0] rd_ptr [NUM_CHANNELS];
  logic [LOG2_QUEUE_LENGTH-1:0] wr_ptr [NUM_CHANNELS];
  logic [CNT_W-1:0]             count  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] full, nonempty, wr_en, pop_ch, overflow;
  logic [CH_W-1:0]         rr_ptr, held_ch, arb_ch, grant, rr_next;
  logic                    any_valid, pop, arb_found;
  arb_state_t              state, state_next;

  always_comb begin
    full          = '0;
    nonempty      = '0;
    wr_en         = '0;
    almost_full_o = '0;
    count_o       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full[c]          = (count[c] == CNT_W'(DEPTH));
      nonempty[c]      = (count[c] != '0);
      wr_en[c]         = dispatched_instr_valid_i[c] && !full[c];
      almost_full_o[c] = (count[c] >= CNT_W'(ALMOST_FULL_THRESH));
      count_o[c*CNT_W +: CNT_W] = count[c];
    end
  end

  assign any_valid = |nonempty;
  assign pop       = any_valid && ready_for_next_instr_i;

  // First non-empty channel at or after rr_ptr, wrapping around.
  always_comb begin
    arb_ch    = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!arb_found && nonempty[(int'(rr_ptr) + i) % NUM_CHANNELS]) begin
        arb_found = 1'b1;
        arb_ch    = CH_W'((int'(rr_ptr) + i) % NUM_CHANNELS);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_FREE: if (any_valid && !ready_for_next_instr_i) state_next = ARB_HELD;
      ARB_HELD: if (pop) state_next = ARB_FREE;
      default:  state_next = ARB_FREE;
    endcase
  end

  assign grant   = (state == ARB_HELD) ? held_ch : arb_ch;
  assign rr_next = (grant == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    pop_ch = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      pop_ch[c] = pop && (grant == CH_W'(c));
    end
  end

  assign is_full_o                  = full;
  assign overflow_o                 = overflow;
  assign curr_instr_to_exec_valid_o = any_valid;
  assign curr_instr_channel_o       = grant;
  assign curr_instr_to_exec_o       = any_valid ? mem[grant][rd_ptr[grant]] : '0;

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en[c]) mem[c][wr_ptr[c]] <= dispatched_instr_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        count[c]  <= '0;
      end
      overflow <= '0;
      rr_ptr   <= '0;
      held_ch  <= '0;
      state    <= ARB_FREE;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en[c])  wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop_ch[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({wr_en[c], pop_ch[c]})
          2'b10:   count[c] <= count[c] + 1'b1;
          2'b01:   count[c] <= count[c] - 1'b1;
          default: count[c] <= count[c];
        endcase
        if (dispatched_instr_valid_i[c] && full[c]) overflow[c] <= 1'b1;
      end
      state <= state_next;
      if (any_valid && !ready_for_next_instr_i) held_ch <= grant;
      if (pop) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_back_icon_iqueue_mc.sv
// Directed plus randomized bench for back_icon_iqueue_mc (2 channels, depth 4, 8-bit data),
// compared every cycle against a queue-based reference model.
module tb_back_icon_iqueue_mc;

  localparam int N  = 2;
  localparam int LQ = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [N*DW-1:0] din;
  logic [N-1:0]  dv;
  logic [N-1:0]  full, af, ovf;
  logic [N*(LQ+1)-1:0] cnt;
  logic [DW-1:0] dout;
  logic [0:0]    ch;
  logic          v, rdy;

  back_icon_iqueue_mc #(
    .NUM_CHANNELS(N), .LOG2_QUEUE_LENGTH(LQ), .DATA_WIDTH(DW), .ALMOST_FULL_THRESH(2)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .dispatched_instr_i(din), .dispatched_instr_valid_i(dv),
    .is_full_o(full), .almost_full_o(af), .count_o(cnt), .overflow_o(ovf),
    .curr_instr_to_exec_o(dout), .curr_instr_channel_o(ch),
    .curr_instr_to_exec_valid_o(v), .ready_for_next_instr_i(rdy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: one queue per channel plus arbitration bookkeeping.
  logic [7:0] mq[2][$];
  bit         movf[2];
  int         mrr;
  bit         mlk;
  int         mlkch;
  logic [7:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mgrant();
    if (mlk) return mlkch;
    for (int i = 0; i < N; i++) begin
      if (mq[(mrr + i) % N].size() > 0) return (mrr + i) % N;
    end
    return 0;
  endfunction

  function automatic bit mvalid();
    return (mq[0].size() + mq[1].size()) > 0;
  endfunction

  task automatic check_all();
    int g;
    chk("valid", v, mvalid());
    if (mvalid()) begin
      g = mgrant();
      chk("channel", ch, g);
      chk("data", dout, mq[g][0]);
    end
    for (int c = 0; c < N; c++) begin
      chk($sformatf("count%0d", c), cnt[c*3 +: 3], mq[c].size());
      chk($sformatf("full%0d", c), full[c], mq[c].size() == 4);
      chk($sformatf("almost_full%0d", c), af[c], mq[c].size() >= 2);
      chk($sformatf("overflow%0d", c), ovf[c], movf[c]);
    end
  endtask

  task automatic model_edge(input logic [1:0] wv, input logic [7:0] d0, input logic [7:0] d1,
                            input logic r, input logic fl, input logic rs);
    bit was_full[2];
    int g;
    if (rs || fl) begin
      mq[0].delete();
      mq[1].delete();
      movf[0] = 1'b0;
      movf[1] = 1'b0;
      mrr = 0;
      mlk = 1'b0;
      mlkch = 0;
      return;
    end
    for (int c = 0; c < N; c++) was_full[c] = (mq[c].size() == 4);
    if (mvalid()) begin
      g = mgrant();
      if (r) begin
        void'(mq[g].pop_front());
        mlk = 1'b0;
        mrr = (g + 1) % N;
      end else begin
        mlk = 1'b1;
        mlkch = g;
      end
    end
    if (wv[0]) begin
      if (was_full[0]) movf[0] = 1'b1; else mq[0].push_back(d0);
    end
    if (wv[1]) begin
      if (was_full[1]) movf[1] = 1'b1; else mq[1].push_back(d1);
    end
  endtask

  task automatic step(input logic [1:0] wv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic r, input logic fl = 1'b0, input logic rs = 1'b0);
    dv    = wv;
    din   = {d1, d0};
    rdy   = r;
    flush = fl;
    reset = rs;
    #1;
    check_all();
    if (v && r && !fl && !rs) popped.push_back(dout);
    @(posedge clk);
    model_edge(wv, d0, d1, r, fl, rs);
    #1;
  endtask

  initial begin
    logic [7:0] exp2[4];
    reset = 1'b1;
    flush = 1'b0;
    dv    = '0;
    din   = '0;
    rdy   = 1'b0;
    repeat (2) @(posedge clk);
    model_edge(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;

    // 1: idle after reset
    step(2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("t1_valid", v, 1'b0);
    chk("t1_full", full, 2'b00);
    chk("t1_count", cnt, 6'd0);
    chk("t1_overflow", ovf, 2'b00);
    chk("t1_channel", ch, 1'b0);

    // 2: interleaved round-robin drain
    popped.delete();
    step(2'b11, 8'h11, 8'h21, 1'b0);
    step(2'b11, 8'h12, 8'h22, 1'b1);
    repeat (4) step(2'b00, 8'h00, 8'h00, 1'b1);
    chk("t2_valid_end", v, 1'b0);
    exp2 = '{8'h11, 8'h21, 8'h12, 8'h22};
    chk("t2_pop_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk($sformatf("t2_pop%0d", i), popped[i], exp2[i]);

    // 3: overfill channel 0
    popped.delete();
    for (int i = 0; i < 5; i++) step(2'b01, 8'hA0 + 8'(i), 8'h00, 1'b0);
    chk("t3_count0", cnt[2:0], 3'd4);
    chk("t3_full0", full[0], 1'b1);
    chk("t3_af0", af[0], 1'b1);
    chk("t3_ovf0", ovf[0], 1'b1);
    repeat (5) step(2'b00, 8'h00, 8'h00, 1'b1);
    chk("t3_pop_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk($sformatf("t3_pop%0d", i), popped[i], 8'hA0 + 8'(i));
    chk("t3_ovf_sticky", ovf[0], 1'b1);

    // 4: lock holds ch1 although ch0 becomes eligible
    step(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    step(2'b10, 8'h00, 8'h30, 1'b0);
    step(2'b01, 8'h40, 8'h00, 1'b0);
    chk("t4_hold_ch", ch, 1'b1);
    chk("t4_hold_data", dout, 8'h30);
    step(2'b00, 8'h00, 8'h00, 1'b0);
    chk("t4_hold_ch2", ch, 1'b1);
    chk("t4_hold_data2", dout, 8'h30);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    chk("t4_next_ch", ch, 1'b0);
    chk("t4_next_data", dout, 8'h40);
    step(2'b00, 8'h00, 8'h00, 1'b1);

    // 5: write+pop on full and non-full channel
    for (int i = 0; i < 4; i++) step(2'b01, 8'h50 + 8'(i), 8'h00, 1'b0);
    chk("t5_full_count", cnt[2:0], 3'd4);
    step(2'b01, 8'h54, 8'h00, 1'b1);
    chk("t5_count3", cnt[2:0], 3'd3);
    chk("t5_ovf", ovf[0], 1'b1);
    step(2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b01, 8'h55, 8'h00, 1'b1);
    chk("t5_count2", cnt[2:0], 3'd2);
    repeat (3) step(2'b00, 8'h00, 8'h00, 1'b1);

    // 6: flush and reset mid-traffic
    for (int i = 0; i < 4; i++) step(2'b11, 8'h60 + 8'(i), 8'h70 + 8'(i), 1'b0);
    chk("t6_both_full", cnt, 6'b100100);
    step(2'b11, 8'h66, 8'h77, 1'b1, 1'b1);
    chk("t6_flush_count", cnt, 6'd0);
    chk("t6_flush_valid", v, 1'b0);
    chk("t6_flush_ovf", ovf, 2'b00);
    repeat (3) step(2'b11, 8'h80, 8'h90, 1'b0);
    step(2'b11, 8'h81, 8'h91, 1'b1, 1'b0, 1'b1);
    chk("t6_reset_count", cnt, 6'd0);
    chk("t6_reset_valid", v, 1'b0);
    chk("t6_reset_ovf", ovf, 2'b00);
    chk("t6_reset_ch", ch, 1'b0);

    // Random traffic with phases of light and heavy consumer backpressure
    for (int i = 0; i < 600; i++) begin
      logic r;
      r = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), r,
           $urandom_range(0, 79) == 0, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
